// File: rtl/rf_framer_pkg.sv
// Shared types and default parameters for the RF packet framer.
// Mode encodings follow the {M1, M0} pin order.
package rf_framer_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_WAKEUP  = 2'd1,
        MODE_PWRSAVE = 2'd2,
        MODE_SLEEP   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StPreamble,
        StSend,
        StGap
    } state_e;

    localparam int unsigned DefDataWidth         = 8;
    localparam int unsigned DefFifoDepth         = 512;
    localparam int unsigned DefIdleTimeout       = 2000;
    localparam int unsigned DefMaxPacketLen      = 58;
    localparam int unsigned DefWakeupPreambleLen = 4;
    localparam logic [7:0]  DefPreambleByte      = 8'hAA;

endpackage

// File: rtl/rf_packet_framer_if.sv
// UART-side handshake bundle: node byte input and MCU byte output.
// master = environment (node UART + MCU UART), slave = framer.
interface rf_framer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RX_flag_node;
    logic [DATA_WIDTH-1:0] data_from_uart_node;
    logic                  TX_flag_mcu;
    logic                  TX_use_mcu;
    logic [DATA_WIDTH-1:0] data_to_uart_mcu;

    modport master (
        output RX_flag_node, data_from_uart_node, TX_flag_mcu,
        input  TX_use_mcu, data_to_uart_mcu
    );

    modport slave (
        input  RX_flag_node, data_from_uart_node, TX_flag_mcu,
        output TX_use_mcu, data_to_uart_mcu
    );
endinterface

// File: rtl/rf_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// A push while full is dropped even if a pop happens in the same cycle.
module rf_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rf_packet_framer.sv
// Buffers node-UART bytes and releases them to the MCU UART in bursts, with
// wake-up preamble, sleep/RX-disable modes, AUX busy and sticky overflow.
module rf_packet_framer
    import rf_framer_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH          = DefDataWidth,
    parameter int unsigned           FIFO_DEPTH          = DefFifoDepth,
    parameter int unsigned           IDLE_TIMEOUT        = DefIdleTimeout,
    parameter int unsigned           MAX_PACKET_LEN      = DefMaxPacketLen,
    parameter int unsigned           WAKEUP_PREAMBLE_LEN = DefWakeupPreambleLen,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE       = DATA_WIDTH'(DefPreambleByte)
) (
    input  logic       internal_clk,
    input  logic       rst_n,
    input  logic       M0_sync,
    input  logic       M1_sync,
    rf_framer_if.slave uart,
    output logic       AUX,
    output logic       overflow_flag
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned BW = $clog2(MAX_PACKET_LEN + 1);
    localparam int unsigned PW = $clog2(WAKEUP_PREAMBLE_LEN + 2);
    localparam logic [CW-1:0] MaxLen   = CW'(MAX_PACKET_LEN);
    localparam logic [IW-1:0] IdleLast = IW'(IDLE_TIMEOUT - 1);

    state_e                state_q, state_d;
    mode_e                 mode;
    logic                  rx_q, push_q, accept;
    logic [DATA_WIDTH-1:0] push_data_q;
    logic [IW-1:0]         idle_q, idle_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic                  tx_use_q, tx_use_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  aux_q, ovf_q, ovf_d;
    logic                  fifo_pop, fifo_clear, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]         fifo_count;

    assign mode   = mode_e'({M1_sync, M0_sync});
    assign accept = (mode == MODE_NORMAL) || (mode == MODE_WAKEUP);

    rf_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (internal_clk),
        .rst_n (rst_n),
        .clear (fifo_clear),
        .push  (push_q),
        .wdata (push_data_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Idle time is measured from the last accepted byte and saturates.
    always_comb begin
        idle_d = idle_q;
        if (push_q)                 idle_d = '0;
        else if (idle_q != IdleLast) idle_d = idle_q + IW'(1);
    end

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        pre_d      = pre_q;
        tx_use_d   = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        ovf_d      = ovf_q || (push_q && fifo_full);
        unique case (state_q)
            StIdle: begin
                if (mode == MODE_SLEEP) fifo_clear = 1'b1;
                else if (push_q)        state_d = StCollect;
            end
            StCollect: begin
                if (mode == MODE_SLEEP) begin
                    fifo_clear = 1'b1;
                    state_d    = StIdle;
                end else if (fifo_count >= MaxLen || idle_q == IdleLast) begin
                    burst_d = (fifo_count >= MaxLen) ? BW'(MAX_PACKET_LEN) : BW'(fifo_count);
                    if (mode == MODE_WAKEUP && WAKEUP_PREAMBLE_LEN != 0) begin
                        pre_d   = PW'(WAKEUP_PREAMBLE_LEN);
                        state_d = StPreamble;
                    end else begin
                        pre_d   = '0;
                        state_d = StSend;
                    end
                end
            end
            StPreamble: begin
                if (!uart.TX_flag_mcu) begin
                    tx_use_d  = 1'b1;
                    tx_data_d = PREAMBLE_BYTE;
                    pre_d     = pre_q - PW'(1);
                    state_d   = StGap;
                end
            end
            StSend: begin
                if (!uart.TX_flag_mcu) begin
                    fifo_pop  = 1'b1;
                    tx_use_d  = 1'b1;
                    tx_data_d = fifo_rdata;
                    burst_d   = burst_q - BW'(1);
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (pre_q != '0)                  state_d = StPreamble;
                else if (burst_q != '0)           state_d = StSend;
                else if (!fifo_empty || push_q)   state_d = StCollect;
                else                              state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (fifo_clear) ovf_d = 1'b0;
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rx_q        <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            idle_q      <= '0;
            burst_q     <= '0;
            pre_q       <= '0;
            tx_use_q    <= 1'b0;
            tx_data_q   <= '0;
            aux_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= uart.RX_flag_node;
            push_q      <= uart.RX_flag_node && !rx_q && accept;
            push_data_q <= uart.data_from_uart_node;
            idle_q      <= idle_d;
            burst_q     <= burst_d;
            pre_q       <= pre_d;
            tx_use_q    <= tx_use_d;
            tx_data_q   <= tx_data_d;
            aux_q       <= (state_q == StIdle) && fifo_empty;
            ovf_q       <= ovf_d;
        end
    end

    assign uart.TX_use_mcu       = tx_use_q;
    assign uart.data_to_uart_mcu = tx_data_q;
    assign AUX                   = aux_q;
    assign overflow_flag         = ovf_q;

endmodule

// File: tb/tb_rf_packet_framer.sv
// Self-checking bench for rf_packet_framer: directed scenarios plus random
// bursts compared against a byte-stream reference model.
module tb_rf_packet_framer;
    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned TMO    = 64;
    localparam int unsigned MAXLEN = 58;
    localparam int unsigned PRELEN = 4;
    localparam logic [7:0]  PRE    = 8'hAA;

    logic internal_clk = 1'b0;
    logic rst_n        = 1'b0;
    logic M0_sync      = 1'b0;
    logic M1_sync      = 1'b0;
    logic AUX, overflow_flag;

    rf_framer_if #(.DATA_WIDTH(DW)) uart ();

    rf_packet_framer #(
        .DATA_WIDTH          (DW),
        .FIFO_DEPTH          (DEPTH),
        .IDLE_TIMEOUT        (TMO),
        .MAX_PACKET_LEN      (MAXLEN),
        .WAKEUP_PREAMBLE_LEN (PRELEN),
        .PREAMBLE_BYTE       (PRE)
    ) dut (
        .internal_clk  (internal_clk),
        .rst_n         (rst_n),
        .M0_sync       (M0_sync),
        .M1_sync       (M1_sync),
        .uart          (uart),
        .AUX           (AUX),
        .overflow_flag (overflow_flag)
    );

    always #5 internal_clk = ~internal_clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    longint     cyc     = 0;
    longint     last_push = 0;
    logic [7:0] got_q [$];
    longint     got_t [$];
    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    bit         hold_tx   = 1'b0;
    bit         toggle_tx = 1'b0;
    logic       prev_use  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // MCU UART model and output monitor; TX_flag_mcu changes only at negedges.
    always @(negedge internal_clk) begin
        cyc = cyc + 1;
        if (rst_n && uart.TX_use_mcu === 1'b1) begin
            got_q.push_back(uart.data_to_uart_mcu);
            got_t.push_back(cyc);
            check("strobe_while_busy", uart.TX_flag_mcu, 1'b0);
            check("strobe_spacing", prev_use, 1'b0);
        end
        prev_use = uart.TX_use_mcu;
        uart.TX_flag_mcu = hold_tx ? 1'b1 : (toggle_tx ? ($urandom_range(0, 3) == 0) : 1'b0);
    end

    task automatic set_mode(input logic [1:0] m);
        @(negedge internal_clk);
        M0_sync = m[0];
        M1_sync = m[1];
    endtask

    task automatic push_byte(input logic [7:0] b, input int hi, input int lo);
        @(negedge internal_clk);
        uart.data_from_uart_node = b;
        uart.RX_flag_node = 1'b1;
        last_push = cyc;
        repeat (hi) @(negedge internal_clk);
        uart.RX_flag_node = 1'b0;
        repeat (lo) @(negedge internal_clk);
    endtask

    task automatic push_src(input bit fast);
        foreach (src_q[i]) begin
            if (fast) push_byte(src_q[i], 1, 0);
            else      push_byte(src_q[i], $urandom_range(1, 2), $urandom_range(1, 4));
        end
    endtask

    // Reference: accepted bytes leave in order; in wake-up mode every burst
    // of up to MAXLEN bytes is preceded by the preamble.
    task automatic build_exp(input logic [1:0] m, input int n_acc);
        exp_q.delete();
        for (int i = 0; i < n_acc; i++) begin
            if (m == 2'd1 && (i % MAXLEN) == 0)
                for (int j = 0; j < PRELEN; j++) exp_q.push_back(PRE);
            exp_q.push_back(src_q[i]);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((got_q.size() < exp_q.size() || AUX !== 1'b1) && k < 20000) begin
            @(negedge internal_clk);
            k++;
        end
        check({tag, "_drain_bound"}, k < 20000, 1'b1);
        repeat (TMO + 8) @(negedge internal_clk);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        got_t.delete();
    endtask

    task automatic rand_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [1:0] m;
        int         n;
        int         snap;
        int         k;
        uart.RX_flag_node = 1'b0;
        uart.data_from_uart_node = '0;

        // Reset state
        #2;
        check("rst_tx_use", uart.TX_use_mcu, 1'b0);
        check("rst_data", uart.data_to_uart_mcu, 8'h00);
        check("rst_aux", AUX, 1'b0);
        check("rst_ovf", overflow_flag, 1'b0);
        repeat (3) @(negedge internal_clk);
        rst_n = 1'b1;
        #1 check("aux_low_at_release", AUX, 1'b0);
        @(negedge internal_clk);
        check("aux_after_release", AUX, 1'b1);

        // Transparent mode, timeout-triggered burst
        src_q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        push_src(1'b0);
        check("t1_aux_busy", AUX, 1'b0);
        build_exp(2'd0, 7);
        wait_drain("t1");
        if (got_t.size() > 0) check("t1_timeout_respected", (got_t[0] - last_push) >= TMO, 1'b1);
        check("t1_aux_idle", AUX, 1'b1);
        compare_stream("t1");

        // Wake-up preamble
        set_mode(2'd1);
        src_q = '{8'h11, 8'h22};
        push_src(1'b0);
        build_exp(2'd1, 2);
        wait_drain("t2");
        compare_stream("t2");

        // Max-length forced flush
        set_mode(2'd0);
        rand_src(60);
        push_src(1'b1);
        build_exp(2'd0, 60);
        wait_drain("t3");
        if (got_t.size() == 60) begin
            check("t3_early_flush", got_t[0] < last_push + TMO, 1'b1);
            check("t3_tail_after_timeout", got_t[MAXLEN] >= last_push + TMO, 1'b1);
        end
        compare_stream("t3");

        // Overflow with MCU blocked
        hold_tx = 1'b1;
        rand_src(DEPTH + 2);
        push_src(1'b1);
        repeat (4) @(negedge internal_clk);
        check("t4_overflow", overflow_flag, 1'b1);
        check("t4_no_strobe_held", got_q.size(), 0);
        hold_tx = 1'b0;
        build_exp(2'd0, DEPTH);
        wait_drain("t4");
        compare_stream("t4");
        check("t4_overflow_sticky", overflow_flag, 1'b1);

        // RX disabled: input ignored
        set_mode(2'd2);
        rand_src(5);
        push_src(1'b0);
        repeat (TMO + 10) @(negedge internal_clk);
        check("t6_pwrsave_ignored", got_q.size(), 0);
        check("t6_pwrsave_aux", AUX, 1'b1);

        // Sleep clears the FIFO and overflow_flag
        set_mode(2'd0);
        rand_src(5);
        push_src(1'b1);
        set_mode(2'd3);
        repeat (4) @(negedge internal_clk);
        check("t6_sleep_ovf_clear", overflow_flag, 1'b0);
        check("t6_sleep_aux", AUX, 1'b1);
        set_mode(2'd0);
        repeat (TMO + 10) @(negedge internal_clk);
        check("t6_sleep_flushed", got_q.size(), 0);

        // Draining continues after switching to RX-disabled mode
        rand_src(3);
        push_src(1'b1);
        set_mode(2'd2);
        build_exp(2'd0, 3);
        wait_drain("t6_drain");
        compare_stream("t6_drain");
        set_mode(2'd0);

        // Random bursts with a busy MCU UART
        toggle_tx = 1'b1;
        for (int p = 0; p < 8; p++) begin
            m = 2'($urandom_range(0, 2));
            n = (m == 2'd1) ? $urandom_range(1, MAXLEN) : $urandom_range(1, 2 * MAXLEN);
            set_mode(m);
            rand_src(n);
            push_src(1'b0);
            build_exp(m, (m == 2'd2) ? 0 : n);
            wait_drain($sformatf("rnd%0d", p));
            compare_stream($sformatf("rnd%0d", p));
            set_mode(2'd0);
        end

        // Reset mid-burst
        rand_src(20);
        push_src(1'b0);
        k = 0;
        while (got_q.size() == 0 && k < 2000) begin
            @(negedge internal_clk);
            k++;
        end
        check("rst_burst_started", got_q.size() > 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_use", uart.TX_use_mcu, 1'b0);
        check("rst_mid_data", uart.data_to_uart_mcu, 8'h00);
        check("rst_mid_aux", AUX, 1'b0);
        check("rst_mid_ovf", overflow_flag, 1'b0);
        repeat (2) @(negedge internal_clk);
        rst_n = 1'b1;
        snap = got_q.size();
        repeat (TMO + 10) @(negedge internal_clk);
        check("rst_mid_fifo_empty", got_q.size(), snap);
        check("rst_mid_aux_idle", AUX, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
